// File: rtl/descrambler_pkg.sv
// rtl/descrambler_pkg.sv - shared constants and state type for the Phase-2 descrambler
package descrambler_pkg;

    localparam logic [15:0] DEF_SYNC_WORD   = 16'h5A5A;
    localparam int          DEF_SYNC_LEN    = 64;
    localparam int          DEF_PAYLOAD_LEN = 1024;
    localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

    // Feedback taps s[15], s[13], s[12], s[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/descrambler_lfsr16_word.sv
// rtl/descrambler_lfsr16_word.sv - 16 LFSR steps per call: keystream word (MSB-first) and advanced state
module lfsr16_word
    import descrambler_pkg::*;
(
    input  logic [15:0] state_i,
    output logic [15:0] key_o,
    output logic [15:0] next_o
);

    logic [15:0] s;

    always_comb begin
        s     = state_i;
        key_o = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            key_o[15-b] = s[15];
            s           = {s[14:0], ^(s & LFSR_TAPS)};
        end
        next_o = s;
    end

endmodule

// File: rtl/descrambler.sv
// rtl/descrambler.sv - frame-synchronous additive descrambler: hunt preamble, XOR payload with keystream
module descrambler
    import descrambler_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int          SYNC_LEN    = DEF_SYNC_LEN,
    parameter int          PAYLOAD_LEN = DEF_PAYLOAD_LEN,
    parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] scramble_data,
    output logic [15:0] descramble_data,
    output logic        data_valid
);

    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam int PW = $clog2(PAYLOAD_LEN);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
    localparam logic [PW-1:0] PAY_LAST  = PW'(PAYLOAD_LEN - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [PW-1:0] pay_cnt_q, pay_cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   dout_q, dout_d;
    logic          valid_q, valid_d;
    logic [15:0]   key_word;
    logic [15:0]   lfsr_next;

    lfsr16_word u_lfsr (
        .state_i (lfsr_q),
        .key_o   (key_word),
        .next_o  (lfsr_next)
    );

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        lfsr_d     = lfsr_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        case (state_q)
            HUNT: begin
                // An unknown sample must not count as a match, so only a true equality advances
                if (scramble_data == SYNC_WORD) begin
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d    = PAYLOAD;
                        sync_cnt_d = '0;
                        pay_cnt_d  = '0;
                        lfsr_d     = LFSR_SEED;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                    end
                end else begin
                    sync_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                dout_d  = scramble_data ^ key_word;
                valid_d = 1'b1;
                lfsr_d  = lfsr_next;
                if (pay_cnt_q == PAY_LAST) begin
                    state_d    = HUNT;
                    sync_cnt_d = '0;
                    pay_cnt_d  = '0;
                end else begin
                    pay_cnt_d = pay_cnt_q + PW'(1);
                end
            end
            default: begin
                state_d    = HUNT;
                sync_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            sync_cnt_q <= '0;
            pay_cnt_q  <= '0;
            lfsr_q     <= LFSR_SEED;
            dout_q     <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            lfsr_q     <= lfsr_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
        end
    end

    assign descramble_data = dout_q;
    assign data_valid      = valid_q;

endmodule

// File: tb/tb_descrambler.sv
// tb/tb_descrambler.sv - scoreboard bench for descrambler against a bit-serial stream model
module tb_descrambler;
    import descrambler_pkg::*;

    localparam int NS = DEF_SYNC_LEN;
    localparam int NP = DEF_PAYLOAD_LEN;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] scramble_data;
    logic [15:0] descramble_data;
    logic        data_valid;

    always #5 clk = ~clk;

    descrambler dut (
        .clk             (clk),
        .reset           (reset),
        .scramble_data   (scramble_data),
        .descramble_data (descramble_data),
        .data_valid      (data_valid)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] firsts[$];
    logic [15:0] ks[NP];
    logic [15:0] pt[NP];
    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    logic        prev_valid = 1'b0;
    int          m_sync;
    int          m_idx;
    logic [15:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Keystream as one continuous bit stream from the seed, cut into MSB-first words
    task automatic build_ks();
        logic [15:0] s;
        logic        fb;
        s = DEF_LFSR_SEED;
        for (int k = 0; k < NP; k++) begin
            for (int b = 0; b < 16; b++) begin
                ks[k][15-b] = s[15];
                fb = s[15] ^ s[13] ^ s[12] ^ s[10];
                s  = {s[14:0], fb};
            end
        end
    endtask

    task automatic model_reset();
        m_sync = 0;
        m_idx  = -1;
        m_last = 16'h0000;
        expq.delete();
    endtask

    task automatic model_step(input logic [15:0] w);
        exp_t e;
        if (m_idx < 0) begin
            if (w === DEF_SYNC_WORD) begin
                m_sync++;
                if (m_sync == NS) begin
                    m_sync = 0;
                    m_idx  = 0;
                end
            end else begin
                m_sync = 0;
            end
            e.v = 1'b0;
            e.d = m_last;
        end else begin
            m_last = w ^ ks[m_idx];
            e.v = 1'b1;
            e.d = m_last;
            m_idx++;
            if (m_idx == NP) m_idx = -1;
        end
        expq.push_back(e);
    endtask

    task automatic send(input logic [15:0] w);
        @(negedge clk);
        scramble_data = w;
        model_step(w);
    endtask

    task automatic send_sync(input int n);
        for (int i = 0; i < n; i++) send(DEF_SYNC_WORD);
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) send(pt[i] ^ ks[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(16'h0000);
    endtask

    task automatic rand_pt();
        for (int i = 0; i < NP; i++) pt[i] = 16'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        scramble_data = 'x;
        model_reset();
        #1;
        check("reset_valid_now", {31'd0, data_valid}, 32'd0);
        check("reset_data_now", {16'd0, descramble_data}, 32'd0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("reset_valid_hold", {31'd0, data_valid}, 32'd0);
            check("reset_data_hold", {16'd0, descramble_data}, 32'd0);
        end
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("out_valid", {31'd0, data_valid}, {31'd0, e.v});
                check("out_data", {16'd0, descramble_data}, {16'd0, e.d});
            end
            if (data_valid) begin
                valid_cnt++;
                if (!prev_valid) firsts.push_back(descramble_data);
            end
            prev_valid = data_valid;
        end
    end

    initial begin : stim
        int base;
        reset = 1'b0;
        scramble_data = 'x;
        build_ks();
        model_reset();

        // Reset, then idle unknown input: no lock
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            scramble_data = 'x;
            model_step(16'hxxxx);
        end
        check("idle_no_valid", valid_cnt, 0);

        // Full frame with triangle-wave payload
        for (int i = 0; i < NP; i++) pt[i] = (i < NP / 2) ? 16'(i * 64) : 16'((NP - 1 - i) * 64);
        base = valid_cnt;
        firsts.delete();
        send_sync(NS);
        send_payload(NP);
        idle(4);
        check("tri_count", valid_cnt - base, NP);
        check("tri_first", {16'd0, firsts[0]}, {16'd0, pt[0]});

        // Zero scrambled payload exposes the raw keystream
        base = valid_cnt;
        firsts.delete();
        send_sync(NS);
        idle(NP);
        idle(4);
        check("ks_count", valid_cnt - base, NP);
        check("ks_first_seed", {16'd0, firsts[0]}, 32'h0000ACE1);

        // Broken preamble; surplus sync word becomes payload word 0
        rand_pt();
        pt[0] = DEF_SYNC_WORD ^ DEF_LFSR_SEED;
        base = valid_cnt;
        firsts.delete();
        send_sync(NS - 1);
        send(16'h0000);
        send_sync(NS);
        send_payload(NP);
        idle(4);
        check("broken_count", valid_cnt - base, NP);
        check("broken_first", {16'd0, firsts[0]}, {16'd0, pt[0]});

        // Reset after payload word 500, then a clean frame
        rand_pt();
        base = valid_cnt;
        send_sync(NS);
        send_payload(501);
        do_reset(2);
        check("midreset_partial", valid_cnt - base, 501);
        rand_pt();
        base = valid_cnt;
        firsts.delete();
        send_sync(NS);
        send_payload(NP);
        idle(4);
        check("midreset_count", valid_cnt - base, NP);
        check("midreset_first", {16'd0, firsts[0]}, {16'd0, pt[0]});

        // Back-to-back frames, no gap
        rand_pt();
        base = valid_cnt;
        firsts.delete();
        send_sync(NS);
        send_payload(NP);
        send_sync(NS);
        send_payload(NP);
        idle(4);
        check("b2b_count", valid_cnt - base, 2 * NP);
        check("b2b_frames", firsts.size(), 2);
        if (firsts.size() >= 2)
            check("b2b_second_first", {16'd0, firsts[1]}, {16'd0, pt[0]});

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
